alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
- Shares the single ALU between N_REQ instruction-issue requesters, such as decode/control units on separate instruction streams.
- Grants requests round-robin and allows one ALU operation in flight at a time.
- Drives the ALU valid/ready handshake and returns a one-cycle completion pulse to the requester that owned the operation.
- Sits between the issue/control stage and the ALU/register-file write-back.

Parameters:
N_REQ, 2, number of requesters (2..4)
ADDR_WIDTH, 5, register address width
OPER_WIDTH, 2, ALU operation code width
TIMEOUT_CYCLES, 255, WAIT-state cycle limit (used only with ALU_TIMEOUT_EN)

Ports:
i_CLK  in  1  clock
i_RSTn  in  1  reset, asynchronous, active-low
i_req_valid  in  N_REQ  per-requester request valid
o_req_ready  out  N_REQ  one-hot accept; a transfer occurs on a clock edge where valid&ready
i_req_oper  in  N_REQ*OPER_WIDTH  flattened op codes; requester k uses slice k
i_req_dest  in  N_REQ*ADDR_WIDTH  flattened destination register addresses
o_req_done  out  N_REQ  one-hot, one-cycle completion pulse to the owning requester
o_alu_valid  out  1  operation presented to ALU
i_alu_ready  in  1  ALU accepts the operation
o_alu_oper  out  OPER_WIDTH  latched op code
o_dest_addr  out  ADDR_WIDTH  latched destination address, for write-back
i_alu_done  in  1  ALU result written back (one-cycle pulse)
o_busy  out  1  high in ISSUE or WAIT
o_err  out  1  completion was due to a timeout (see Optional Feature)

Behaviour:
- Reset values: o_alu_valid=0, o_alu_oper=0, o_dest_addr=0, o_req_done=0, o_err=0, rr_ptr=N_REQ-1, state=IDLE.
- With state=IDLE after reset, o_req_ready=0 and o_busy=0 until a request arrives.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - o_req_ready is combinational: one-hot grant, asserted only in IDLE.
  - Grant search starts at index (rr_ptr+1) mod N_REQ and moves upward with wrap; the first valid requester wins.
  - On a transfer, latch oper/dest slices of grant index g into o_alu_oper/o_dest_addr, store g, set o_alu_valid=1, go to ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE:
  - Hold o_alu_valid, o_alu_oper and o_dest_addr stable until an edge with i_alu_ready=1.
  - At that edge: o_alu_valid<=0, go to WAIT.
  - If i_alu_done=1 on the same edge: skip WAIT and complete immediately (done handling below).
- WAIT: on i_alu_done=1, o_req_done[g]<=1 for exactly one cycle, rr_ptr<=g, go to IDLE.
- Latency:
  - Accept at edge 0 → o_alu_valid high from cycle 1.
  - Minimum accept-to-done-pulse is 2 cycles (ALU ready and done at edge 1, pulse in cycle 2).
  - Next grant is possible in the cycle the done pulse is visible.
- i_alu_done in IDLE, or in ISSUE without i_alu_ready, is ignored.
- o_req_ready is 0 in ISSUE and WAIT; requesters hold valid and payload stable until ready.
- Requests are not pipelined: at most one operation is outstanding.
- Asynchronous reset mid-operation drops the in-flight operation; no done pulse is generated for it.
- With a single requester continuously valid, that requester is granted back-to-back (one grant per completed operation).

Optional Feature:
- Macro: ALU_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter, width $clog2(TIMEOUT_CYCLES+1), clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without i_alu_done: o_req_done[g] pulses with o_err=1 in the same cycle, rr_ptr<=g, go to IDLE.
  - o_err is otherwise 0.
- Undefined: WAIT holds indefinitely, o_err is tied 0, and no counter exists.

Decomposition:
- Shared package alu_pkg:
  - state enum {IDLE, ISSUE, WAIT};
  - OPER_WIDTH and ADDR_WIDTH defaults;
  - ALU op-code constants shared with the control block.
- One sub-module, rr_grant: combinational round-robin one-hot picker with inputs req[N_REQ] and ptr and output grant[N_REQ].

Test Plan:
- N_REQ=2; req0 valid with oper=2'b01, dest=5'd7; ALU ready at once; done 3 cycles later → o_req_ready=2'b01 at cycle 0; o_alu_valid cycle 1 with oper=1, dest=7; o_req_done=2'b01 for exactly one cycle.
- Both requesters continuously valid for 4 operations → grants alternate 0,1,0,1, never the same requester twice in a row.
- i_alu_ready held low 5 cycles in ISSUE → o_alu_valid, oper and dest stay stable for all 5 cycles; no o_req_ready asserted.
- i_alu_ready and i_alu_done both high on the same edge → done pulse next cycle; WAIT never entered; rr_ptr updated.
- Assert i_RSTn=0 during WAIT → all outputs reach reset values immediately; no done pulse; next grant goes to requester 0.
- With ALU_TIMEOUT_EN and TIMEOUT_CYCLES=10, no i_alu_done → after 10 WAIT cycles, o_req_done[g]=1 and o_err=1 for one cycle, then IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue arbiter and the control block.
// Holds the arbiter FSM states, default widths and ALU op-code constants.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int ALU_OPER_WIDTH = 2;
    localparam int ALU_ADDR_WIDTH = 5;

    localparam logic [ALU_OPER_WIDTH-1:0] ALU_OP_ADD = 2'b00;
    localparam logic [ALU_OPER_WIDTH-1:0] ALU_OP_SUB = 2'b01;
    localparam logic [ALU_OPER_WIDTH-1:0] ALU_OP_AND = 2'b10;
    localparam logic [ALU_OPER_WIDTH-1:0] ALU_OP_OR  = 2'b11;

endpackage

// File: rtl/alu_issue_arbiter_rr_grant.sv
// Combinational round-robin one-hot picker.
// Ports: req (request vector), ptr (last winner), grant (one-hot winner).
module rr_grant
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = $clog2(N_REQ)
)
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Search starts just after the last winner and wraps.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one ALU between N_REQ requesters,
// one operation in flight. Optional WAIT timeout: define ALU_TIMEOUT_EN.
// Ports: i_CLK, i_RSTn (async active-low); i_req_valid/o_req_ready
// request handshake with flattened i_req_oper/i_req_dest; o_req_done
// completion pulse; o_alu_valid/i_alu_ready ALU handshake with
// o_alu_oper/o_dest_addr; i_alu_done write-back pulse; o_busy; o_err.
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int ADDR_WIDTH     = ALU_ADDR_WIDTH,
    parameter int OPER_WIDTH     = ALU_OPER_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic                          i_CLK,
    input  logic                          i_RSTn,
    input  logic [N_REQ-1:0]              i_req_valid,
    output logic [N_REQ-1:0]              o_req_ready,
    input  logic [N_REQ*OPER_WIDTH-1:0]   i_req_oper,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   i_req_dest,
    output logic [N_REQ-1:0]              o_req_done,
    output logic                          o_alu_valid,
    input  logic                          i_alu_ready,
    output logic [OPER_WIDTH-1:0]         o_alu_oper,
    output logic [ADDR_WIDTH-1:0]         o_dest_addr,
    input  logic                          i_alu_done,
    output logic                          o_busy,
    output logic                          o_err
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("alu_issue_arbiter: unsupported parameter set");
    end

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       owner;
    logic [N_REQ-1:0]       grant;
    logic [PTR_W-1:0]       gnt_idx;
    logic [OPER_WIDTH-1:0]  gnt_oper;
    logic [ADDR_WIDTH-1:0]  gnt_dest;
    logic [N_REQ-1:0]       owner_vec;

    rr_grant #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_grant (
        .req   (i_req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Encode the one-hot winner and mux its payload slices.
    always_comb begin
        gnt_idx  = '0;
        gnt_oper = '0;
        gnt_dest = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                gnt_idx  = PTR_W'(k);
                gnt_oper = i_req_oper[k*OPER_WIDTH +: OPER_WIDTH];
                gnt_dest = i_req_dest[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign o_req_ready = (state == IDLE) ? grant : '0;
    assign o_busy      = (state != IDLE);
    assign owner_vec   = {{(N_REQ-1){1'b0}}, 1'b1} << owner;

`ifdef ALU_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;

    logic [CNT_W-1:0] to_cnt;
    logic             err_q;

    assign o_err = err_q;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state       <= IDLE;
            rr_ptr      <= PTR_W'(N_REQ - 1);
            owner       <= '0;
            o_alu_valid <= 1'b0;
            o_alu_oper  <= '0;
            o_dest_addr <= '0;
            o_req_done  <= '0;
            to_cnt      <= '0;
            err_q       <= 1'b0;
        end else begin
            o_req_done <= '0;
            err_q      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        owner       <= gnt_idx;
                        o_alu_oper  <= gnt_oper;
                        o_dest_addr <= gnt_dest;
                        o_alu_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_alu_ready) begin
                        o_alu_valid <= 1'b0;
                        to_cnt      <= '0;
                        if (i_alu_done) begin
                            o_req_done <= owner_vec;
                            rr_ptr     <= owner;
                            state      <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // The count is compared before increment, so the
                    // abort lands on the TIMEOUT_CYCLES-th WAIT edge.
                    if (i_alu_done) begin
                        o_req_done <= owner_vec;
                        rr_ptr     <= owner;
                        state      <= IDLE;
                    end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        o_req_done <= owner_vec;
                        err_q      <= 1'b1;
                        rr_ptr     <= owner;
                        state      <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign o_err = 1'b0;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state       <= IDLE;
            rr_ptr      <= PTR_W'(N_REQ - 1);
            owner       <= '0;
            o_alu_valid <= 1'b0;
            o_alu_oper  <= '0;
            o_dest_addr <= '0;
            o_req_done  <= '0;
        end else begin
            o_req_done <= '0;
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        owner       <= gnt_idx;
                        o_alu_oper  <= gnt_oper;
                        o_dest_addr <= gnt_dest;
                        o_alu_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_alu_ready) begin
                        o_alu_valid <= 1'b0;
                        if (i_alu_done) begin
                            o_req_done <= owner_vec;
                            rr_ptr     <= owner;
                            state      <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (i_alu_done) begin
                        o_req_done <= owner_vec;
                        rr_ptr     <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter (N_REQ=2).
// Directed vector table, hand sequences and a randomized model check.
module tb_alu_issue_arbiter;

    localparam int N  = 2;
    localparam int OW = 2;
    localparam int AW = 5;
    localparam int TO = 10;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*OW-1:0] req_oper;
    logic [N*AW-1:0] req_dest;
    logic [N-1:0]    req_done;
    logic            alu_valid;
    logic            alu_ready;
    logic [OW-1:0]   alu_oper;
    logic [AW-1:0]   dest_addr;
    logic            alu_done;
    logic            busy;
    logic            err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(
        .N_REQ          (N),
        .ADDR_WIDTH     (AW),
        .OPER_WIDTH     (OW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_CLK       (clk),
        .i_RSTn      (rstn),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_oper  (req_oper),
        .i_req_dest  (req_dest),
        .o_req_done  (req_done),
        .o_alu_valid (alu_valid),
        .i_alu_ready (alu_ready),
        .o_alu_oper  (alu_oper),
        .o_dest_addr (dest_addr),
        .i_alu_done  (alu_done),
        .o_busy      (busy),
        .o_err       (err)
    );

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*OW-1:0] oper;
        logic [N*AW-1:0] dest;
        logic            ar;
        logic            ad;
        logic [N-1:0]    e_ready;
        logic            e_av;
        logic [OW-1:0]   e_oper;
        logic [AW-1:0]   e_dest;
        logic [N-1:0]    e_done;
        logic            e_busy;
    } vec_t;

    vec_t tv[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        req_oper  = '0;
        req_dest  = '0;
        alu_ready = 1'b0;
        alu_done  = 1'b0;
        cyc();
        cyc();
        rstn = 1'b1;
    endtask

    // Reference pick: first valid requester after the last winner.
    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int            w;
        int            prev;
        int            n;
        int            last;
        int            owner;
        int            g;
        int            wcnt;
        bit            outst;
        bit            taken;
        logic [OW-1:0] m_oper;
        logic [AW-1:0] m_dest;
        logic [N-1:0]  e_ready;
        logic [N-1:0]  e_done;
        logic          e_err;
        logic [N-1:0]  pend;
        logic [OW-1:0] p_oper[N];
        logic [AW-1:0] p_dest[N];

        tv[0]  = '{2'b01, {2'd0, 2'd1}, {5'd0, 5'd7}, 1'b1, 1'b0,
                   2'b01, 1'b1, 2'd1, 5'd7, 2'b00, 1'b1};
        tv[1]  = '{2'b00, {2'd0, 2'd1}, {5'd0, 5'd7}, 1'b1, 1'b0,
                   2'b00, 1'b0, 2'd1, 5'd7, 2'b00, 1'b1};
        tv[2]  = '{2'b00, {2'd0, 2'd0}, {5'd0, 5'd0}, 1'b1, 1'b0,
                   2'b00, 1'b0, 2'd1, 5'd7, 2'b00, 1'b1};
        tv[3]  = '{2'b00, {2'd0, 2'd0}, {5'd0, 5'd0}, 1'b1, 1'b0,
                   2'b00, 1'b0, 2'd1, 5'd7, 2'b00, 1'b1};
        tv[4]  = '{2'b00, {2'd0, 2'd0}, {5'd0, 5'd0}, 1'b1, 1'b1,
                   2'b00, 1'b0, 2'd1, 5'd7, 2'b01, 1'b0};
        tv[5]  = '{2'b00, {2'd0, 2'd0}, {5'd0, 5'd0}, 1'b0, 1'b1,
                   2'b00, 1'b0, 2'd1, 5'd7, 2'b00, 1'b0};
        tv[6]  = '{2'b10, {2'd2, 2'd0}, {5'd20, 5'd0}, 1'b0, 1'b0,
                   2'b10, 1'b1, 2'd2, 5'd20, 2'b00, 1'b1};
        for (int r = 7; r < 12; r++) begin
            tv[r] = '{2'b01, {2'd0, 2'd3}, {5'd0, 5'd9}, 1'b0, 1'b1,
                      2'b00, 1'b1, 2'd2, 5'd20, 2'b00, 1'b1};
        end
        tv[12] = '{2'b01, {2'd0, 2'd3}, {5'd0, 5'd9}, 1'b1, 1'b1,
                   2'b00, 1'b0, 2'd2, 5'd20, 2'b10, 1'b0};
        tv[13] = '{2'b01, {2'd0, 2'd3}, {5'd0, 5'd9}, 1'b0, 1'b0,
                   2'b01, 1'b1, 2'd3, 5'd9, 2'b00, 1'b1};
        tv[14] = '{2'b00, {2'd0, 2'd0}, {5'd0, 5'd0}, 1'b1, 1'b0,
                   2'b00, 1'b0, 2'd3, 5'd9, 2'b00, 1'b1};

        // Reset values
        req_valid = 2'b11;
        req_oper  = '1;
        req_dest  = '1;
        alu_ready = 1'b0;
        alu_done  = 1'b0;
        #2;
        chk("rst alu_valid", 32'(alu_valid), 0);
        chk("rst oper", 32'(alu_oper), 0);
        chk("rst dest", 32'(dest_addr), 0);
        chk("rst done", 32'(req_done), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst err", 32'(err), 0);
        do_reset();
        #1;
        chk("idle ready", 32'(req_ready), 0);
        chk("idle busy", 32'(busy), 0);

        // Directed vector table
        for (int r = 0; r < 15; r++) begin
            req_valid = tv[r].valid;
            req_oper  = tv[r].oper;
            req_dest  = tv[r].dest;
            alu_ready = tv[r].ar;
            alu_done  = tv[r].ad;
            #1;
            chk($sformatf("tv%0d ready", r), 32'(req_ready),
                32'(tv[r].e_ready));
            cyc();
            chk($sformatf("tv%0d alu_valid", r), 32'(alu_valid),
                32'(tv[r].e_av));
            chk($sformatf("tv%0d oper", r), 32'(alu_oper),
                32'(tv[r].e_oper));
            chk($sformatf("tv%0d dest", r), 32'(dest_addr),
                32'(tv[r].e_dest));
            chk($sformatf("tv%0d done", r), 32'(req_done),
                32'(tv[r].e_done));
            chk($sformatf("tv%0d busy", r), 32'(busy),
                32'(tv[r].e_busy));
            chk($sformatf("tv%0d err", r), 32'(err), 0);
        end

        // Asynchronous reset while in WAIT drops the operation
        alu_ready = 1'b0;
        alu_done  = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        chk("arst alu_valid", 32'(alu_valid), 0);
        chk("arst oper", 32'(alu_oper), 0);
        chk("arst dest", 32'(dest_addr), 0);
        chk("arst done", 32'(req_done), 0);
        chk("arst busy", 32'(busy), 0);
        chk("arst ready", 32'(req_ready), 0);
        cyc();
        rstn      = 1'b1;
        req_valid = 2'b11;
        req_oper  = {2'd2, 2'd1};
        req_dest  = {5'd3, 5'd4};
        alu_ready = 1'b1;
        alu_done  = 1'b1;
        #1;
        chk("arst no done", 32'(req_done), 0);

        // Both continuously valid: grants alternate starting at 0
        prev = -1;
        for (int op = 0; op < 4; op++) begin
            w = 0;
            while (req_ready == '0 && w < 10) begin
                cyc();
                w++;
            end
            chk($sformatf("alt%0d grant", op), 32'(req_ready),
                (op % 2 == 0) ? 32'h1 : 32'h2);
            if (prev >= 0)
                chk($sformatf("alt%0d done", op), 32'(req_done),
                    32'(1 << prev));
            prev = op % 2;
            cyc();
        end

        // Randomized check against reference model
        do_reset();
        last   = N - 1;
        outst  = 0;
        taken  = 0;
        owner  = 0;
        wcnt   = 0;
        m_oper = '0;
        m_dest = '0;
        pend   = '0;
        for (int k = 0; k < N; k++) begin
            p_oper[k] = '0;
            p_dest[k] = '0;
        end
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && ($urandom % 3 == 0)) begin
                    pend[k]   = 1'b1;
                    p_oper[k] = OW'($urandom);
                    p_dest[k] = AW'($urandom);
                end
                req_oper[k*OW +: OW] = p_oper[k];
                req_dest[k*AW +: AW] = p_dest[k];
            end
            req_valid = pend;
            alu_ready = 1'($urandom % 2);
            alu_done  = ($urandom % 3 == 0);

            e_ready = '0;
            e_done  = '0;
            e_err   = 1'b0;
            if (!outst) begin
                g = pick(pend, last);
                if (g >= 0) begin
                    e_ready = N'(1 << g);
                    outst   = 1;
                    taken   = 0;
                    owner   = g;
                    m_oper  = p_oper[g];
                    m_dest  = p_dest[g];
                    pend[g] = 1'b0;
                end
            end else if (!taken) begin
                if (alu_ready) begin
                    taken = 1;
                    wcnt  = 0;
                    if (alu_done) begin
                        e_done = N'(1 << owner);
                        last   = owner;
                        outst  = 0;
                    end
                end
            end else if (alu_done) begin
                e_done = N'(1 << owner);
                last   = owner;
                outst  = 0;
            end else begin
`ifdef ALU_TIMEOUT_EN
                wcnt++;
                if (wcnt == TO) begin
                    e_done = N'(1 << owner);
                    e_err  = 1'b1;
                    last   = owner;
                    outst  = 0;
                end
`endif
            end

            #1;
            chk($sformatf("rnd%0d ready", c), 32'(req_ready), 32'(e_ready));
            cyc();
            chk($sformatf("rnd%0d alu_valid", c), 32'(alu_valid),
                32'(outst && !taken));
            chk($sformatf("rnd%0d oper", c), 32'(alu_oper), 32'(m_oper));
            chk($sformatf("rnd%0d dest", c), 32'(dest_addr), 32'(m_dest));
            chk($sformatf("rnd%0d done", c), 32'(req_done), 32'(e_done));
            chk($sformatf("rnd%0d busy", c), 32'(busy), 32'(outst));
            chk($sformatf("rnd%0d err", c), 32'(err), 32'(e_err));
        end

`ifdef ALU_TIMEOUT_EN
        // WAIT timeout with no ALU completion
        do_reset();
        req_valid = 2'b10;
        req_oper  = {2'd3, 2'd0};
        req_dest  = {5'd31, 5'd0};
        alu_ready = 1'b1;
        alu_done  = 1'b0;
        #1;
        chk("to grant", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        n = 0;
        while (req_done == '0 && n < 30) begin
            cyc();
            n++;
        end
        chk("to edges", 32'(n), 11);
        chk("to done", 32'(req_done), 32'h2);
        chk("to err", 32'(err), 1);
        cyc();
        chk("to done clr", 32'(req_done), 0);
        chk("to err clr", 32'(err), 0);
        chk("to idle", 32'(busy), 0);
`else
        n = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
